// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA on clk and delivers per-channel words.
// Build macro I2S_RX_STEREO_LATCH_EN: hold each left word and deliver left/right as one pair.
module i2s_receiver #(
    parameter int unsigned DATASIZE = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                BCLK,
    input  logic                LRCLK,
    input  logic                SDATA,
    output logic [DATASIZE-1:0] leftAudio,
    output logic [DATASIZE-1:0] rightAudio,
    output logic                leftValid,
    output logic                rightValid,
    output logic                frameError
);

    localparam int unsigned     CntW    = $clog2(DATASIZE + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATASIZE - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(DATASIZE);

    typedef enum logic {StSync, StReceive} state_e;

    // bclk_sync_q[2] is the extra stage used only for rising-edge detection
    logic [2:0]          bclk_sync_q;
    logic [1:0]          lrclk_sync_q;
    logic [1:0]          sdata_sync_q;

    state_e              state_q, state_d;
    logic                lr_prev_q, lr_prev_d;
    logic [DATASIZE-1:0] shift_q, shift_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATASIZE-1:0] left_q, left_d;
    logic [DATASIZE-1:0] right_q, right_d;
    logic                left_valid_q, left_valid_d;
    logic                right_valid_q, right_valid_d;
    logic                frame_error_q, frame_error_d;
`ifdef I2S_RX_STEREO_LATCH_EN
    logic [DATASIZE-1:0] held_q, held_d;
    logic                held_valid_q, held_valid_d;
`endif

    logic                bclk_rise;
    logic                lr_smp;
    logic                sd_smp;
    logic                boundary;
    logic [DATASIZE-1:0] word;

    assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign lr_smp    = lrclk_sync_q[1];
    assign sd_smp    = sdata_sync_q[1];
    assign boundary  = bclk_rise & (lr_smp != lr_prev_q);
    // At a boundary the incoming bit is the LSB of the word just finished (one-bit I2S delay)
    assign word      = {shift_q[DATASIZE-2:0], sd_smp};

    always_comb begin
        state_d       = state_q;
        lr_prev_d     = lr_prev_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        left_d        = left_q;
        right_d       = right_q;
        left_valid_d  = 1'b0;
        right_valid_d = 1'b0;
        frame_error_d = 1'b0;
`ifdef I2S_RX_STEREO_LATCH_EN
        held_d        = held_q;
        held_valid_d  = held_valid_q;
`endif

        if (bclk_rise) begin
            lr_prev_d = lr_smp;
            shift_d   = word;
            if (enable) begin
                unique case (state_q)
                    StSync: begin
                        if (boundary) begin
                            cnt_d   = '0;
                            state_d = StReceive;
                        end
                    end
                    StReceive: begin
                        if (boundary) begin
                            cnt_d = '0;
                            if (cnt_q == LastCnt) begin
`ifdef I2S_RX_STEREO_LATCH_EN
                                if (!lr_prev_q) begin
                                    held_d       = word;
                                    held_valid_d = 1'b1;
                                end else if (held_valid_q) begin
                                    left_d        = held_q;
                                    right_d       = word;
                                    left_valid_d  = 1'b1;
                                    right_valid_d = 1'b1;
                                    held_valid_d  = 1'b0;
                                end
`else
                                if (!lr_prev_q) begin
                                    left_d       = word;
                                    left_valid_d = 1'b1;
                                end else begin
                                    right_d       = word;
                                    right_valid_d = 1'b1;
                                end
`endif
                            end else begin
                                frame_error_d = 1'b1;
                            end
                        end else if (cnt_q != MaxCnt) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    default: state_d = StSync;
                endcase
            end
        end

        // Disabled: stay in sync hunt; LRCLK history keeps tracking so re-entry needs two boundaries
        if (!enable) begin
            state_d       = StSync;
            cnt_d         = '0;
            left_valid_d  = 1'b0;
            right_valid_d = 1'b0;
            frame_error_d = 1'b0;
`ifdef I2S_RX_STEREO_LATCH_EN
            held_valid_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_q   <= '0;
            lrclk_sync_q  <= '0;
            sdata_sync_q  <= '0;
            state_q       <= StSync;
            lr_prev_q     <= 1'b0;
            shift_q       <= '0;
            cnt_q         <= '0;
            left_q        <= '0;
            right_q       <= '0;
            left_valid_q  <= 1'b0;
            right_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef I2S_RX_STEREO_LATCH_EN
            held_q        <= '0;
            held_valid_q  <= 1'b0;
`endif
        end else begin
            bclk_sync_q   <= {bclk_sync_q[1:0], BCLK};
            lrclk_sync_q  <= {lrclk_sync_q[0], LRCLK};
            sdata_sync_q  <= {sdata_sync_q[0], SDATA};
            state_q       <= state_d;
            lr_prev_q     <= lr_prev_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            right_q       <= right_d;
            left_valid_q  <= left_valid_d;
            right_valid_q <= right_valid_d;
            frame_error_q <= frame_error_d;
`ifdef I2S_RX_STEREO_LATCH_EN
            held_q        <= held_d;
            held_valid_q  <= held_valid_d;
`endif
        end
    end

    assign leftAudio  = left_q;
    assign rightAudio = right_q;
    assign leftValid  = left_valid_q;
    assign rightValid = right_valid_q;
    assign frameError = frame_error_q;

endmodule
